// File: rtl/uart_rx_frame_assembler.sv
// rtl/uart_rx_frame_assembler.sv - UART RX frame assembler (LSB-first), optional parity via UART_RX_PARITY_EN
module uart_rx_frame_assembler #(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 bit_sample,
    input  logic                 bit_valid,
    input  logic                 start_detected,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_read,
    input  logic                 err_clr,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_complete,
    output logic                 error_clear,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 overrun_error
);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    state_t                 state_q, state_d;
    logic [2:0]             cnt_q, cnt_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   fc_q, fc_d;
    logic                   ec_q, ec_d;
    logic                   fe_q, fe_d;
    logic                   oe_q, oe_d;
    logic                   complete;

`ifdef UART_RX_PARITY_EN
    logic                   par_q, par_d;
    logic                   pe_q, pe_d;
`else
    logic                   unused_parity_cfg;
    assign unused_parity_cfg = parity_en ^ parity_odd;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        fe_d       = fe_q;
        oe_d       = oe_q;
        complete   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
        pe_d       = pe_q;
`endif
        // A start strobe always (re)begins a frame, discarding any partial word.
        if (start_detected) begin
            state_d = S_DATA;
            cnt_d   = 3'd0;
            shift_d = '0;
`ifdef UART_RX_PARITY_EN
            par_d   = 1'b0;
`endif
        end else if (bit_valid) begin
            unique case (state_q)
                S_DATA: begin
                    shift_d = {bit_sample, shift_q[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
                    par_d   = par_q ^ bit_sample;
`endif
                    if (cnt_q == LAST_DATA) begin
                        cnt_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = parity_en ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (par_q ^ bit_sample ^ parity_odd) pe_d = 1'b1;
                    state_d = S_STOP;
                end
`endif
                S_STOP: begin
                    if (!bit_sample) fe_d = 1'b1;
                    if (cnt_q == LAST_STOP) begin
                        state_d  = S_IDLE;
                        cnt_d    = 3'd0;
                        complete = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end

        if (err_clr) begin
            state_d = S_IDLE;
            cnt_d   = 3'd0;
            fe_d    = 1'b0;
            oe_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
            pe_d    = 1'b0;
`endif
        end

        // Handshake runs after the clear so an overrun at completion survives err_clr.
        if (rx_read && rx_valid_q) rx_valid_d = 1'b0;
        if (complete) begin
            if (!rx_valid_q || rx_read) begin
                rx_data_d  = shift_q;
                rx_valid_d = 1'b1;
            end else begin
                oe_d = 1'b1;
            end
        end

        fc_d = complete;
        ec_d = err_clr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            shift_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            fc_q       <= 1'b0;
            ec_q       <= 1'b0;
            fe_q       <= 1'b0;
            oe_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            pe_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            fc_q       <= fc_d;
            ec_q       <= ec_d;
            fe_q       <= fe_d;
            oe_q       <= oe_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            pe_q       <= pe_d;
`endif
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign frame_complete = fc_q;
    assign error_clear    = ec_q;
    assign framing_error  = fe_q;
    assign overrun_error  = oe_q;
`ifdef UART_RX_PARITY_EN
    assign parity_error   = pe_q;
`else
    assign parity_error   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame_assembler.sv
// tb/tb_uart_rx_frame_assembler.sv - randomized bench for uart_rx_frame_assembler (8N1 and 6N2 instances)
module tb_uart_rx_frame_assembler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] sd, bv, bs, rd, ec;
    logic       par_en, par_odd;
    logic [7:0] rx_data_a;
    logic [5:0] rx_data_b;
    logic [1:0] rv, fc, ecl, fe, pe, oe;

    int vectors = 0;
    int errors  = 0;

    int exp_data [2];
    bit exp_valid [2];
    bit exp_fe [2];
    bit exp_pe [2];
    bit exp_oe [2];
    int fc_cnt [2];

    uart_rx_frame_assembler #(.DATA_BITS(8), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .bit_sample(bs[0]), .bit_valid(bv[0]),
        .start_detected(sd[0]), .parity_en(par_en), .parity_odd(par_odd),
        .rx_read(rd[0]), .err_clr(ec[0]), .rx_data(rx_data_a), .rx_valid(rv[0]),
        .frame_complete(fc[0]), .error_clear(ecl[0]), .framing_error(fe[0]),
        .parity_error(pe[0]), .overrun_error(oe[0])
    );

    uart_rx_frame_assembler #(.DATA_BITS(6), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .bit_sample(bs[1]), .bit_valid(bv[1]),
        .start_detected(sd[1]), .parity_en(par_en), .parity_odd(par_odd),
        .rx_read(rd[1]), .err_clr(ec[1]), .rx_data(rx_data_b), .rx_valid(rv[1]),
        .frame_complete(fc[1]), .error_clear(ecl[1]), .framing_error(fe[1]),
        .parity_error(pe[1]), .overrun_error(oe[1])
    );

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) if (fc[i] === 1'b1) fc_cnt[i]++;
    end

    initial begin
        #3000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_data[i] = 0; exp_valid[i] = 0;
            exp_fe[i] = 0; exp_pe[i] = 0; exp_oe[i] = 0;
        end
    endtask

    task automatic do_read(input int u);
        rd[u] = 1'b1; cycle(); rd[u] = 1'b0;
        exp_valid[u] = 0;
    endtask

    task automatic do_err_clr(input int u);
        ec[u] = 1'b1; cycle(); ec[u] = 1'b0;
        exp_fe[u] = 0; exp_pe[u] = 0; exp_oe[u] = 0;
    endtask

    // Drives one frame with random inter-bit gaps; stopmask bit j = 1 sends stop bit j as 0.
    task automatic send_frame(input int u, input int data, input int stopmask,
                              input bit rd_end, input int parbit);
        int db, sb, d;
        db = (u == 0) ? 8 : 6;
        sb = (u == 0) ? 1 : 2;
        d  = data & ((1 << db) - 1);
        sd[u] = 1'b1; cycle(); sd[u] = 1'b0;
        for (int i = 0; i < db; i++) begin
            repeat ($urandom_range(0, 2)) cycle();
            bs[u] = d[i]; bv[u] = 1'b1; cycle(); bv[u] = 1'b0;
        end
        if (parbit >= 0) begin
            repeat ($urandom_range(0, 2)) cycle();
            bs[u] = parbit[0]; bv[u] = 1'b1; cycle(); bv[u] = 1'b0;
        end
        for (int j = 0; j < sb; j++) begin
            repeat ($urandom_range(0, 2)) cycle();
            bs[u] = ~stopmask[j]; bv[u] = 1'b1;
            if (j == sb - 1) rd[u] = rd_end;
            cycle();
            bv[u] = 1'b0; rd[u] = 1'b0;
            vectors++;
            if (fc[u] !== (j == sb - 1)) begin
                errors++;
                $display("FAIL frame_complete_u%0d_stop%0d: got %b want %b", u, j, fc[u], (j == sb - 1));
            end
        end
        if ((stopmask & ((1 << sb) - 1)) != 0) exp_fe[u] = 1;
        if (parbit >= 0 && ((($countones(d) + parbit + int'(par_odd)) % 2) == 1)) exp_pe[u] = 1;
        if (!exp_valid[u] || rd_end) begin
            exp_data[u]  = d;
            exp_valid[u] = 1;
        end else begin
            exp_oe[u] = 1;
        end
    endtask

    task automatic test_reset();
        repeat (3) cycle();
        vectors++;
        if ({rv, fc, ecl, fe, pe, oe} !== 12'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0", {rv, fc, ecl, fe, pe, oe});
        end
        vectors++;
        if (rx_data_a !== 8'h00 || rx_data_b !== 6'h00) begin
            errors++;
            $display("FAIL reset_data: got %h/%h want 00/00", rx_data_a, rx_data_b);
        end
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_basic();
        int c0;
        c0 = fc_cnt[0];
        send_frame(0, 'hA5, 0, 0, -1);
        cycle();
        vectors++;
        if (rx_data_a !== 8'hA5 || rv[0] !== 1'b1) begin
            errors++;
            $display("FAIL basic_data: got %h valid %b want a5 valid 1", rx_data_a, rv[0]);
        end
        vectors++;
        if (fe[0] !== 1'b0 || pe[0] !== 1'b0 || oe[0] !== 1'b0 || fc_cnt[0] - c0 != 1) begin
            errors++;
            $display("FAIL basic_flags: got fe%b pe%b oe%b pulses %0d want 0 0 0 1",
                     fe[0], pe[0], oe[0], fc_cnt[0] - c0);
        end
        do_read(0);
        vectors++;
        if (rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL basic_read: got valid %b want 0", rv[0]);
        end
    endtask

    task automatic test_overrun();
        send_frame(0, 'h3C, 0, 0, -1);
        send_frame(0, 'h7E, 0, 0, -1);
        vectors++;
        if (oe[0] !== 1'b1 || rx_data_a !== 8'h3C) begin
            errors++;
            $display("FAIL overrun_set: got oe %b data %h want 1 3c", oe[0], rx_data_a);
        end
        do_read(0);
        vectors++;
        if (rv[0] !== 1'b0) begin
            errors++;
            $display("FAIL overrun_read: got valid %b want 0", rv[0]);
        end
        do_read(0);
        vectors++;
        if (rv[0] !== 1'b0 || rx_data_a !== 8'h3C) begin
            errors++;
            $display("FAIL read_when_empty: got valid %b data %h want 0 3c", rv[0], rx_data_a);
        end
        do_err_clr(0);
        vectors++;
        if (oe[0] !== 1'b0 || ecl[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_clr: got oe %b error_clear %b want 0 1", oe[0], ecl[0]);
        end
        cycle();
        vectors++;
        if (ecl[0] !== 1'b0) begin
            errors++;
            $display("FAIL error_clear_pulse: got %b want 0", ecl[0]);
        end
    endtask

    task automatic test_framing();
        send_frame(0, 'h55, 1, 0, -1);
        vectors++;
        if (fe[0] !== 1'b1 || rx_data_a !== 8'h55 || rv[0] !== 1'b1) begin
            errors++;
            $display("FAIL framing: got fe %b data %h valid %b want 1 55 1", fe[0], rx_data_a, rv[0]);
        end
        do_read(0);
        do_err_clr(0);
    endtask

    task automatic test_restart();
        int c0;
        c0 = fc_cnt[0];
        sd[0] = 1'b1; cycle(); sd[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bs[0] = 1'b1; bv[0] = 1'b1; cycle(); bv[0] = 1'b0;
        end
        send_frame(0, 'h12, 0, 0, -1);
        cycle();
        vectors++;
        if (rx_data_a !== 8'h12 || fc_cnt[0] - c0 != 1 || fe[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart: got data %h pulses %0d fe %b want 12 1 0",
                     rx_data_a, fc_cnt[0] - c0, fe[0]);
        end
        do_read(0);
    endtask

    task automatic test_two_stop();
        send_frame(1, 'h2D, 2, 0, -1);
        vectors++;
        if (fe[1] !== 1'b1 || rx_data_b !== 6'h2D || rv[1] !== 1'b1) begin
            errors++;
            $display("FAIL two_stop: got fe %b data %h valid %b want 1 2d 1", fe[1], rx_data_b, rv[1]);
        end
        do_read(1);
        do_err_clr(1);
    endtask

    task automatic test_parity();
`ifdef UART_RX_PARITY_EN
        par_en = 1'b1; par_odd = 1'b0;
        send_frame(0, 'h07, 0, 0, 0);
        vectors++;
        if (pe[0] !== 1'b1) begin
            errors++;
            $display("FAIL parity_bad: got %b want 1", pe[0]);
        end
        do_read(0);
        do_err_clr(0);
        send_frame(0, 'h07, 0, 0, 1);
        vectors++;
        if (pe[0] !== 1'b0 || rx_data_a !== 8'h07) begin
            errors++;
            $display("FAIL parity_good: got pe %b data %h want 0 07", pe[0], rx_data_a);
        end
        do_read(0);
        par_en = 1'b0;
`endif
    endtask

    task automatic test_reset_midframe();
        send_frame(0, 'h5A, 0, 0, -1);
        sd[0] = 1'b1; cycle(); sd[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bs[0] = 1'b0; bv[0] = 1'b1; cycle(); bv[0] = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (rv[0] !== 1'b0 || rx_data_a !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got valid %b data %h want 0 00", rv[0], rx_data_a);
        end
        cycle();
        rst_n = 1'b1;
        model_reset();
        cycle();
        send_frame(0, 'hC3, 0, 0, -1);
        vectors++;
        if (rx_data_a !== 8'hC3 || rv[0] !== 1'b1 || fe[0] !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_frame: got data %h valid %b fe %b want c3 1 0",
                     rx_data_a, rv[0], fe[0]);
        end
        do_read(0);
    endtask

    task automatic test_random();
        int u, got, mask, pb;
        for (int n = 0; n < 40; n++) begin
            u = $urandom_range(0, 1);
            if ($urandom_range(0, 2) == 0) do_read(u);
            if ($urandom_range(0, 5) == 0) do_err_clr(u);
            if ($urandom_range(0, 3) == 0) begin
                bs[u] = 1'($urandom); bv[u] = 1'b1; cycle(); bv[u] = 1'b0;
            end
            mask = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            pb = -1;
`ifdef UART_RX_PARITY_EN
            par_en  = 1'($urandom);
            par_odd = 1'($urandom);
            if (par_en) pb = $urandom_range(0, 1);
`endif
            send_frame(u, $urandom, mask, 1'($urandom_range(0, 1)), pb);
            got = (u == 0) ? int'(rx_data_a) : int'(rx_data_b);
            vectors++;
            if (rv[u] !== exp_valid[u] || got != exp_data[u]) begin
                errors++;
                $display("FAIL random_data_%0d_u%0d: got valid %b data %h want %b %h",
                         n, u, rv[u], got, exp_valid[u], exp_data[u]);
            end
            vectors++;
            if ({fe[u], pe[u], oe[u]} !== {exp_fe[u], exp_pe[u], exp_oe[u]}) begin
                errors++;
                $display("FAIL random_errors_%0d_u%0d: got fe/pe/oe %b%b%b want %b%b%b",
                         n, u, fe[u], pe[u], oe[u], exp_fe[u], exp_pe[u], exp_oe[u]);
            end
        end
        par_en = 1'b0;
    endtask

    initial begin
        sd = '0; bv = '0; bs = '0; rd = '0; ec = '0;
        par_en = 1'b0; par_odd = 1'b0;
        fc_cnt[0] = 0; fc_cnt[1] = 0;
        model_reset();
        test_reset();
        test_basic();
        test_overrun();
        test_framing();
        test_restart();
        test_two_stop();
        test_parity();
        test_reset_midframe();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_assembler.md
Name: uart_rx_frame_assembler

Overview:
Consumes the bit stream from the UART bit sampler (start_detected, bit_valid, bit_sample) and assembles frames LSB-first into a data word.
- Checks optional parity and the stop bit(s).
- Holds the received word in a one-entry output register with a valid/read handshake.
- Drives frame_complete and error_clear back to the bit sampler so it returns to IDLE.
- Sits between the bit sampler and the RX FIFO / register interface.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
STOP_BITS, 1, stop bits checked per frame; legal values 1 or 2.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
bit_sample  input  1  sampled bit value from bit sampler
bit_valid  input  1  one-cycle strobe: bit_sample holds a data/parity/stop bit
start_detected  input  1  one-cycle strobe: valid start bit seen
parity_en  input  1  1 = frame contains a parity bit (used only with UART_RX_PARITY_EN)
parity_odd  input  1  1 = odd parity, 0 = even
rx_read  input  1  consumer pops rx_data (one-cycle pulse)
err_clr  input  1  software clear of sticky errors
rx_data  output  DATA_BITS  received word
rx_valid  output  1  rx_data holds an unread word
frame_complete  output  1  one-cycle pulse, frame finished (to bit sampler)
error_clear  output  1  one-cycle pulse, registered copy of err_clr (to bit sampler)
framing_error  output  1  sticky: a stop bit sampled 0
parity_error  output  1  sticky: parity mismatch
overrun_error  output  1  sticky: frame completed while rx_valid=1 and no rx_read

Behaviour:
Reset values: all outputs 0; rx_data=0; FSM in IDLE; bit counter 0; shift register 0.

FSM states and transitions:
- IDLE: start_detected -> DATA; clear bit counter and parity accumulator. bit_valid in IDLE is ignored.
- DATA: each bit_valid shifts bit_sample into the MSB of the shift register (LSB-first reception) and XORs it into the parity accumulator. When the counter reaches DATA_BITS-1 on bit_valid, go to PARITY if parity is active, else STOP.
- PARITY: on bit_valid, the mismatch test is accumulator ^ bit_sample ^ parity_odd. If the result is 1, set parity_error. Go to STOP.
- STOP: each bit_valid with bit_sample=0 sets framing_error. After STOP_BITS stop strobes, go to IDLE and perform completion.

Completion (registered, the cycle after the final stop-bit bit_valid):
- frame_complete pulses for 1 cycle.
- If rx_valid=0, or rx_read is asserted in the same cycle: load rx_data and set rx_valid=1.
- Otherwise set overrun_error, discard the new word and keep the old one.
- The word is delivered even when a framing or parity error occurred.

rx_valid / rx_read handshake:
- rx_read with rx_valid=1 clears rx_valid next cycle.
- rx_read with rx_valid=0 has no effect.
- rx_data is stable while rx_valid=1.

Other boundary rules:
- start_detected in any non-IDLE state restarts the frame: go to DATA, clear the counter and accumulator, and drop the partial word. No error is flagged.
- err_clr: next cycle clears all three sticky errors, pulses error_clear for 1 cycle, and forces the FSM to IDLE. rx_valid and rx_data are unaffected.
- err_clr coincident with completion: the clear wins for the errors; the data/overrun path still executes, and a new overrun is set after the clear.
- rst_n asserted mid-frame: immediate return to reset values; the partial frame is lost.

Optional Feature:
Macro: UART_RX_PARITY_EN.
- Defined: the PARITY state and accumulator exist; parity_en selects whether a parity bit is expected; parity_odd selects odd or even.
- Undefined: no PARITY state or accumulator; parity_en and parity_odd are ignored; parity_error is tied 0; frames are start + DATA_BITS + STOP_BITS.

Test Plan:
1. Defaults, start_detected, then bits of 0xA5 LSB-first, stop=1 -> frame_complete pulses once; rx_data=0xA5; rx_valid=1; no errors.
2. Two frames 0x3C then 0x7E, no rx_read between them -> overrun_error=1; rx_data stays 0x3C. Then rx_read -> rx_valid=0. Then err_clr -> overrun_error=0 and error_clear pulses.
3. Frame 0x55 with stop bit=0 -> framing_error=1; rx_data=0x55; rx_valid=1.
4. UART_RX_PARITY_EN defined, parity_en=1, parity_odd=0, data 0x07 with parity bit 0 (even parity expects 1) -> parity_error=1. Repeat with parity bit 1 -> no new error.
5. start_detected after 3 data bits, then full frame 0x12 -> rx_data=0x12; exactly one frame_complete.
6. STOP_BITS=2, second stop bit=0 -> framing_error=1. frame_complete fires only after the second stop strobe.
